// File: rtl/esi_int_pkg.sv
// Shared types for the si13 array datapath: scalar element, 4-element array, array size.
package esi_int_pkg;

  typedef logic signed [12:0] si13_t;
  typedef si13_t [3:0] arr4_si13_t;

  localparam int          ARR_N  = 4;
  localparam int unsigned SI13_W = $bits(si13_t);

endpackage : esi_int_pkg

// File: rtl/int_arr_pack_if.sv
// Generic valid/ready stream; master drives data/valid, slave drives ready.
interface int_arr_pack_if #(
  parameter int unsigned W = 13
);

  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input  ready);
  modport slave  (input  data, input  valid, output ready);

endinterface : int_arr_pack_if

// File: rtl/int_arr_collect.sv
// Collect stage: stores the first N-1 elements of an array in slots and flags the
// cycle in which the final element arrives so the caller can complete the array.
module int_arr_collect
  import esi_int_pkg::*;
#(
  parameter int unsigned N     = ARR_N,
  parameter int unsigned WIDTH = SI13_W
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [WIDTH-1:0]              data_i,
  input  logic                          valid_i,
  input  logic                          out_free_i,
  output logic                          ready_c,
  output logic                          done_c,
  output logic [N-2:0][WIDTH-1:0]       slots_o,
  output logic [$clog2(N+1)-1:0]        idx_o
);

  localparam int unsigned       FILL_W = $clog2(N + 1);
  localparam logic [FILL_W-1:0] LAST   = FILL_W'(N - 1);

  logic [FILL_W-1:0]        idx_q, idx_d;
  logic [N-2:0][WIDTH-1:0]  slots_q, slots_d;

  // The last element is only taken when the output register can absorb the array.
  always_comb begin
    ready_c = 1'b0;
    done_c  = 1'b0;
    idx_d   = idx_q;
    slots_d = slots_q;

    if (rstn) begin
      ready_c = (idx_q < LAST) || ((idx_q == LAST) && out_free_i);
    end

    if (valid_i && ready_c) begin
      if (idx_q == LAST) begin
        done_c = 1'b1;
        idx_d  = '0;
      end else begin
        for (int unsigned i = 0; i < N - 1; i++) begin
          if (idx_q == FILL_W'(i)) begin
            slots_d[i] = data_i;
          end
        end
        idx_d = idx_q + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx_q   <= '0;
      slots_q <= '0;
    end else begin
      idx_q   <= idx_d;
      slots_q <= slots_d;
    end
  end

  assign slots_o = slots_q;
  assign idx_o   = idx_q;

endmodule : int_arr_collect

// File: rtl/int_arr_pack.sv
// Packs a scalar si13 valid/ready stream into N-element arrays, element 0 first,
// with an output register so a new array can load in the cycle the old one drains.
module int_arr_pack
  import esi_int_pkg::*;
#(
  parameter int unsigned N     = ARR_N,
  parameter int unsigned WIDTH = SI13_W
) (
  input  logic                     clk,
  input  logic                     rstn,
  int_arr_pack_if.slave            ints,
  int_arr_pack_if.master           arr,
  output logic [$clog2(N+1)-1:0]   fill
);

  localparam int unsigned FILL_W = $clog2(N + 1);

  logic [N-2:0][WIDTH-1:0]  slots;
  logic [FILL_W-1:0]        idx;
  logic                     col_ready_c;
  logic                     done_c;
  logic                     drn_c;
  logic                     out_free_c;

  logic                     out_valid_q;
  logic [N-1:0][WIDTH-1:0]  out_q, out_d;

  assign drn_c      = out_valid_q && arr.ready;
  assign out_free_c = !out_valid_q || drn_c;

  int_arr_collect #(
    .N     (N),
    .WIDTH (WIDTH)
  ) u_collect (
    .clk        (clk),
    .rstn       (rstn),
    .data_i     (ints.data),
    .valid_i    (ints.valid),
    .out_free_i (out_free_c),
    .ready_c    (col_ready_c),
    .done_c     (done_c),
    .slots_o    (slots),
    .idx_o      (idx)
  );

  // Completed array: stored slots plus the element arriving this cycle as the top entry.
  always_comb begin
    out_d = out_q;
    if (done_c) begin
      for (int unsigned i = 0; i < N - 1; i++) begin
        out_d[i] = slots[i];
      end
      out_d[N-1] = ints.data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      out_q <= out_d;
      if (done_c) begin
        out_valid_q <= 1'b1;
      end else if (drn_c) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign ints.ready = col_ready_c;
  assign arr.valid  = out_valid_q;
  assign arr.data   = out_q;
  assign fill       = idx;

endmodule : int_arr_pack

// File: tb/tb_int_arr_pack.sv
// Self-checking bench for int_arr_pack: directed scenarios plus a random phase,
// checked against a queue-based model of accepted elements and pending arrays.
module tb_int_arr_pack;
  import esi_int_pkg::*;

  localparam int unsigned N = ARR_N;
  localparam int unsigned W = SI13_W;

  logic       clk = 1'b0;
  logic       rstn;
  logic [2:0] fill;

  always #5 clk = ~clk;

  int_arr_pack_if #(.W(W))     ints_if ();
  int_arr_pack_if #(.W(N * W)) arr_if ();

  int_arr_pack dut (
    .clk  (clk),
    .rstn (rstn),
    .ints (ints_if),
    .arr  (arr_if),
    .fill (fill)
  );

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned drains = 0;
  int unsigned completes = 0;

  si13_t      partial[$];
  arr4_si13_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic arr4_si13_t pack4(input si13_t e0, input si13_t e1, input si13_t e2, input si13_t e3);
    arr4_si13_t r;
    r[0] = e0; r[1] = e1; r[2] = e2; r[3] = e3;
    return r;
  endfunction

  // Reference model: every N accepted values form one array; arrays leave in order.
  always @(negedge clk) begin : monitor
    arr4_si13_t a;
    logic       exp_rdy;
    if (!rstn) begin
      partial.delete();
      exp_q.delete();
      check("rst_ints_ready", 64'(ints_if.ready), 64'(1'b0));
      check("rst_arr_valid", 64'(arr_if.valid), 64'(1'b0));
      check("rst_fill", 64'(fill), 64'(0));
    end else begin
      check("fill", 64'(fill), 64'(partial.size()));
      check("arr_valid", 64'(arr_if.valid), 64'(exp_q.size() != 0));
      exp_rdy = (partial.size() < N - 1) ||
                ((partial.size() == N - 1) && ((exp_q.size() == 0) || arr_if.ready));
      check("ints_ready", 64'(ints_if.ready), 64'(exp_rdy));
      if (arr_if.valid && exp_q.size() != 0)
        check("arr_data", 64'({arr_if.data}), 64'({exp_q[0]}));
      if (arr_if.valid && arr_if.ready) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        drains++;
      end
      if (ints_if.valid && ints_if.ready) begin
        partial.push_back(si13_t'(ints_if.data));
        if (partial.size() == N) begin
          for (int i = 0; i < 4; i++) a[i] = partial[i];
          exp_q.push_back(a);
          partial.delete();
          completes++;
        end
      end
    end
  end

  // Present one value and hold it until accepted (bounded).
  task automatic send(input si13_t v);
    bit          ok;
    int unsigned n;
    ok = 1'b0;
    n  = 0;
    ints_if.data  = v;
    ints_if.valid = 1'b1;
    while (!ok && n < 64) begin
      @(negedge clk);
      ok = ints_if.ready;
      @(posedge clk);
      #1;
      n++;
    end
    check("send_accepted", 64'(ok), 64'(1'b1));
  endtask

  initial begin : stim
    si13_t       bp[8];
    int unsigned s, d0, c0;

    rstn          = 1'b0;
    ints_if.valid = 1'b0;
    ints_if.data  = '0;
    arr_if.ready  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_arr_valid", 64'(arr_if.valid), 64'(1'b0));
    check("reset_ints_ready", 64'(ints_if.ready), 64'(1'b0));
    check("reset_fill", 64'(fill), 64'(0));
    check("reset_arr_data", 64'({arr_if.data}), 64'(0));
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_ready", 64'(ints_if.ready), 64'(1'b1));

    // Basic pack
    arr_if.ready = 1'b1;
    send(si13_t'(1)); send(si13_t'(-2)); send(si13_t'(3)); send(si13_t'(-4));
    ints_if.valid = 1'b0;
    check("basic_valid", 64'(arr_if.valid), 64'(1'b1));
    check("basic_data", 64'({arr_if.data}),
          64'({pack4(si13_t'(1), si13_t'(-2), si13_t'(3), si13_t'(-4))}));
    check("basic_elem0", 64'(arr_if.data[12:0]), 64'(13'd1));
    check("basic_fill", 64'(fill), 64'(0));
    repeat (2) @(posedge clk);
    #1;

    // Sign and width edges
    send(si13_t'(-4096)); send(si13_t'(4095)); send(si13_t'(0)); send(si13_t'(-1));
    ints_if.valid = 1'b0;
    check("edge_data", 64'({arr_if.data}), 64'({13'h1FFF, 13'h0000, 13'h0FFF, 13'h1000}));
    repeat (2) @(posedge clk);
    #1;

    // Back-pressure: first array held while the second fills behind it
    arr_if.ready = 1'b0;
    for (int i = 0; i < 8; i++) bp[i] = si13_t'($urandom);
    for (int i = 0; i < 7; i++) send(bp[i]);
    ints_if.data  = bp[7];
    ints_if.valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("bp_fill", 64'(fill), 64'(3));
    check("bp_ints_ready", 64'(ints_if.ready), 64'(1'b0));
    check("bp_arr_valid", 64'(arr_if.valid), 64'(1'b1));
    check("bp_hold_data", 64'({arr_if.data}), 64'({pack4(bp[0], bp[1], bp[2], bp[3])}));
    arr_if.ready = 1'b1;
    send(bp[7]);
    ints_if.valid = 1'b0;
    check("bp_b2b_valid", 64'(arr_if.valid), 64'(1'b1));
    check("bp_b2b_data", 64'({arr_if.data}), 64'({pack4(bp[4], bp[5], bp[6], bp[7])}));
    repeat (2) @(posedge clk);
    #1;

    // Streaming counter at full rate
    d0 = drains;
    s  = cyc;
    for (int k = 0; k < 400; k++) send(si13_t'(k));
    ints_if.valid = 1'b0;
    check("stream_cycles", 64'(cyc - s), 64'(400));
    repeat (2) @(posedge clk);
    #1;
    check("stream_arrays", 64'(drains - d0), 64'(100));

    // Reset mid-packet with a pending output
    arr_if.ready = 1'b0;
    for (int i = 0; i < 4; i++) send(si13_t'($urandom));
    send(si13_t'(7)); send(si13_t'(8));
    ints_if.valid = 1'b0;
    rstn = 1'b0;
    #1;
    check("midrst_fill", 64'(fill), 64'(0));
    check("midrst_arr_valid", 64'(arr_if.valid), 64'(1'b0));
    @(posedge clk);
    #1;
    rstn         = 1'b1;
    arr_if.ready = 1'b1;
    send(si13_t'(10)); send(si13_t'(11)); send(si13_t'(12)); send(si13_t'(13));
    ints_if.valid = 1'b0;
    check("midrst_data", 64'({arr_if.data}),
          64'({pack4(si13_t'(10), si13_t'(11), si13_t'(12), si13_t'(13))}));
    repeat (2) @(posedge clk);
    #1;

    // Random valid/ready traffic
    d0 = drains;
    c0 = completes;
    repeat (3000) begin
      @(posedge clk);
      #1;
      arr_if.ready  = ($urandom_range(0, 9) < 7);
      ints_if.valid = ($urandom_range(0, 9) < 6);
      ints_if.data  = 13'($urandom);
    end
    ints_if.valid = 1'b0;
    arr_if.ready  = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rand_all_drained", 64'(drains - d0), 64'(completes - c0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_int_arr_pack
